pixel_fifo: RTL

Byte-to-word packing FIFO that buffers host pixel data for the LED string wrapper. It packs an 8-bit host byte stream into 16-bit words and stores them in a single-clock FIFO. It exposes the fill count, read strobe and registered data/valid interface that the string wrapper pops from. It sits between the host write path and the parallel string driver wrapper.

---
 rtl/pixel_fifo.sv | 94 +++++++++
 1 files changed

// File: rtl/pixel_fifo.sv
// pixel_fifo: packs host bytes into 16-bit words and buffers them in a single-clock FIFO with a registered read port.
// Optional PIXEL_FIFO_STATS_EN adds saturating overflow/underflow counters.
module pixel_fifo #(
    parameter int FIFO_ADDR_WIDTH = 12,
    parameter int FIFO_DATA_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 byte_data,
    input  logic                       byte_valid,
    input  logic                       byte_flush,
    input  logic                       fifo_clear,
    input  logic                       fifo_read,
    output logic [FIFO_DATA_WIDTH-1:0] fifo_data,
    output logic                       fifo_data_valid,
    output logic [FIFO_ADDR_WIDTH:0]   fifo_full_count,
    output logic                       fifo_full,
    output logic [15:0]                overflow_count,
    output logic [15:0]                underflow_count
);
    localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
    localparam logic [FIFO_ADDR_WIDTH:0] FULL_CNT = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};
    localparam logic [FIFO_ADDR_WIDTH:0] CNT_ONE = 1;
    localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE = 1;

    logic [FIFO_DATA_WIDTH-1:0] mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [7:0] partial;
    logic held, held_next, push, empty, rd_ok, wr_ok;
    logic [FIFO_DATA_WIDTH-1:0] word;

    assign fifo_full = fifo_full_count == FULL_CNT;
    assign empty = fifo_full_count == '0;

    // Byte packing: a new byte completes a held one, or is pushed alone on flush, or is held.
    always_comb begin
        push = byte_valid ? (held || byte_flush) : (byte_flush && held);
        word = byte_valid ? (held ? {byte_data, partial} : {8'h00, byte_data}) : {8'h00, partial};
        held_next = byte_valid ? (!held && !byte_flush) : (held && !byte_flush);
        rd_ok = fifo_read && !empty && !fifo_clear;
        wr_ok = push && (!fifo_full || rd_ok) && !fifo_clear;
    end

    // Storage array; reading the old word on a same-address write keeps the full+read+write case correct.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= word;
    end

    // Pointers, count, partial byte and the registered read port; clear wins over everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_full_count <= '0;
            held <= 1'b0;
            partial <= 8'h00;
            fifo_data <= '0;
            fifo_data_valid <= 1'b0;
        end else if (fifo_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_full_count <= '0;
            held <= 1'b0;
            fifo_data_valid <= 1'b0;
        end else begin
            wr_ptr <= wr_ok ? wr_ptr + PTR_ONE : wr_ptr;
            rd_ptr <= rd_ok ? rd_ptr + PTR_ONE : rd_ptr;
            fifo_full_count <= (wr_ok && !rd_ok) ? fifo_full_count + CNT_ONE :
                               (rd_ok && !wr_ok) ? fifo_full_count - CNT_ONE : fifo_full_count;
            held <= held_next;
            partial <= (byte_valid && !held) ? byte_data : partial;
            fifo_data_valid <= rd_ok;
            if (rd_ok) fifo_data <= mem[rd_ptr];
        end
    end

`ifdef PIXEL_FIFO_STATS_EN
    // Saturating event counters; only reset clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_count <= 16'h0000;
            underflow_count <= 16'h0000;
        end else begin
            if (push && fifo_full && !rd_ok && !fifo_clear && overflow_count != 16'hFFFF)
                overflow_count <= overflow_count + 16'h0001;
            if (fifo_read && empty && !fifo_clear && underflow_count != 16'hFFFF)
                underflow_count <= underflow_count + 16'h0001;
        end
    end
`else
    assign overflow_count = 16'h0000;
    assign underflow_count = 16'h0000;
`endif
endmodule
